ysyx_lsu: RTL and testbench

Load/store unit that answers the EXU memory request handshake (`lsu_avalid`, address, write data, op, read/write enable) and turns each request into one transaction on the split read/write data bus (AR/R, AW/W/B channels). It aligns store data and byte strobes, and extracts and extends load data. It returns completion to the EXU as a one-cycle `lsu_exu_rvalid` pulse (loads) or `lsu_exu_wready` pulse (stores). It sits between `ysyx_exu` and the data-side bus arbiter/xbar.

---
 rtl/ysyx_lsu.sv | 205 ++++++++++++++++++++
 tb/tb_ysyx_lsu.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_lsu.sv
// ysyx_lsu: load/store unit between the EXU request handshake and the split
// AR/R + AW/W/B data bus. One transaction outstanding at a time.
// Optional feature macro: YSYX_LSU_MISALIGN_EN (misaligned H/W accesses fault
// in IDLE without touching the bus).
module ysyx_lsu #(
  parameter int unsigned YSYX_W_WIDTH = 32,
  parameter int unsigned BIT_W        = YSYX_W_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  // EXU request side
  input  logic               lsu_avalid,
  input  logic               lsu_ren,
  input  logic               lsu_wen,
  input  logic [BIT_W-1:0]   lsu_addr,
  input  logic [BIT_W-1:0]   lsu_wdata,
  input  logic [2:0]         lsu_op,
  output logic [BIT_W-1:0]   lsu_rdata_o,
  output logic               lsu_exu_rvalid_o,
  output logic               lsu_exu_wready_o,
  output logic               lsu_err_o,
  // Read address channel
  output logic [BIT_W-1:0]   bus_araddr_o,
  output logic [2:0]         bus_arsize_o,
  output logic               bus_arvalid_o,
  input  logic               bus_arready,
  // Read data channel
  input  logic [BIT_W-1:0]   bus_rdata,
  input  logic [1:0]         bus_rresp,
  input  logic               bus_rvalid,
  output logic               bus_rready_o,
  // Write address channel
  output logic [BIT_W-1:0]   bus_awaddr_o,
  output logic [2:0]         bus_awsize_o,
  output logic               bus_awvalid_o,
  input  logic               bus_awready,
  // Write data channel
  output logic [BIT_W-1:0]   bus_wdata_o,
  output logic [BIT_W/8-1:0] bus_wstrb_o,
  output logic               bus_wvalid_o,
  input  logic               bus_wready,
  // Write response channel
  input  logic [1:0]         bus_bresp,
  input  logic               bus_bvalid,
  output logic               bus_bready_o
);

  localparam int unsigned StrbW = BIT_W / 8;
  localparam int unsigned OffW  = $clog2(StrbW);

  typedef enum logic [2:0] {StIdle, StRaddr, StRdata, StWreq, StWresp, StDone} state_e;

  state_e             state_q, state_d;
  logic [BIT_W-1:0]   addr_q, addr_d;
  logic [BIT_W-1:0]   wdata_q, wdata_d;
  logic [2:0]         op_q, op_d;
  logic               load_q, load_d;
  logic               err_q, err_d;
  logic [BIT_W-1:0]   rdata_q, rdata_d;
  logic               aw_done_q, aw_done_d;
  logic               w_done_q, w_done_d;

  logic [OffW-1:0]    off;
  logic [BIT_W-1:0]   rshift;
  logic [BIT_W-1:0]   rext;
  logic [StrbW-1:0]   wmask;
  logic               misalign;

  assign off = addr_q[OffW-1:0];

`ifdef YSYX_LSU_MISALIGN_EN
  // Misalignment is judged on the live request while still in IDLE
  always_comb begin
    misalign = ((lsu_op[1:0] == 2'd1) && lsu_addr[0]) ||
               ((lsu_op[1:0] == 2'd2) && (lsu_addr[1:0] != 2'b00));
  end
`else
  assign misalign = 1'b0;
`endif

  // Load data: move the addressed bytes to bit 0, then extend per funct3
  always_comb begin
    rshift = bus_rdata >> {off, 3'b000};
    case (op_q)
      3'd0:    rext = {{(BIT_W - 8){rshift[7]}}, rshift[7:0]};
      3'd1:    rext = {{(BIT_W - 16){rshift[15]}}, rshift[15:0]};
      3'd4:    rext = {{(BIT_W - 8){1'b0}}, rshift[7:0]};
      3'd5:    rext = {{(BIT_W - 16){1'b0}}, rshift[15:0]};
      default: rext = rshift;
    endcase
  end

  // Store strobe pattern before lane shifting
  always_comb begin
    case (op_q[1:0])
      2'd0:    wmask = StrbW'(1);
      2'd1:    wmask = StrbW'(3);
      default: wmask = '1;
    endcase
  end

  // Next-state and datapath latching
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    op_d      = op_q;
    load_d    = load_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      StIdle: begin
        if (lsu_avalid && (lsu_ren || lsu_wen)) begin
          addr_d    = lsu_addr;
          wdata_d   = lsu_wdata;
          op_d      = lsu_op;
          load_d    = lsu_ren;
          err_d     = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (misalign) begin
            err_d   = 1'b1;
            state_d = StDone;
            if (lsu_ren) rdata_d = '0;
          end else begin
            state_d = lsu_ren ? StRaddr : StWreq;
          end
        end
      end
      StRaddr: begin
        if (bus_arready) state_d = StRdata;
      end
      StRdata: begin
        if (bus_rvalid) begin
          rdata_d = rext;
          err_d   = (bus_rresp != 2'b00);
          state_d = StDone;
        end
      end
      StWreq: begin
        // Each channel remembers its own handshake; leave once both are done
        aw_done_d = aw_done_q || bus_awready;
        w_done_d  = w_done_q || bus_wready;
        if (aw_done_d && w_done_d) state_d = StWresp;
      end
      StWresp: begin
        if (bus_bvalid) begin
          err_d   = (bus_bresp != 2'b00);
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      op_q      <= '0;
      load_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      op_q      <= op_d;
      load_q    <= load_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Outputs decode from registered state only, so they never depend on bus inputs
  always_comb begin
    bus_arvalid_o    = (state_q == StRaddr);
    bus_araddr_o     = addr_q;
    bus_arsize_o     = {1'b0, op_q[1:0]};
    bus_rready_o     = (state_q == StRdata);
    bus_awvalid_o    = (state_q == StWreq) && !aw_done_q;
    bus_awaddr_o     = addr_q;
    bus_awsize_o     = {1'b0, op_q[1:0]};
    bus_wvalid_o     = (state_q == StWreq) && !w_done_q;
    bus_wdata_o      = wdata_q << {off, 3'b000};
    bus_wstrb_o      = (state_q == StWreq) ? StrbW'(wmask << off) : '0;
    bus_bready_o     = (state_q == StWresp);
    lsu_exu_rvalid_o = (state_q == StDone) && load_q;
    lsu_exu_wready_o = (state_q == StDone) && !load_q;
    lsu_err_o        = (state_q == StDone) && err_q;
    lsu_rdata_o      = rdata_q;
  end

endmodule

// File: tb/tb_ysyx_lsu.sv
// Self-checking bench for ysyx_lsu: directed vector table, a reset-abort
// sequence, and randomized transactions checked against a behavioural model.
module tb_ysyx_lsu;

  logic        clk, rst;
  logic        lsu_avalid, lsu_ren, lsu_wen;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [2:0]  lsu_op;
  logic [31:0] lsu_rdata_o;
  logic        lsu_exu_rvalid_o, lsu_exu_wready_o, lsu_err_o;
  logic [31:0] bus_araddr_o;
  logic [2:0]  bus_arsize_o;
  logic        bus_arvalid_o, bus_arready;
  logic [31:0] bus_rdata;
  logic [1:0]  bus_rresp;
  logic        bus_rvalid, bus_rready_o;
  logic [31:0] bus_awaddr_o;
  logic [2:0]  bus_awsize_o;
  logic        bus_awvalid_o, bus_awready;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_wstrb_o;
  logic        bus_wvalid_o, bus_wready;
  logic [1:0]  bus_bresp;
  logic        bus_bvalid, bus_bready_o;

  ysyx_lsu dut (
    .clk              (clk),
    .rst              (rst),
    .lsu_avalid       (lsu_avalid),
    .lsu_ren          (lsu_ren),
    .lsu_wen          (lsu_wen),
    .lsu_addr         (lsu_addr),
    .lsu_wdata        (lsu_wdata),
    .lsu_op           (lsu_op),
    .lsu_rdata_o      (lsu_rdata_o),
    .lsu_exu_rvalid_o (lsu_exu_rvalid_o),
    .lsu_exu_wready_o (lsu_exu_wready_o),
    .lsu_err_o        (lsu_err_o),
    .bus_araddr_o     (bus_araddr_o),
    .bus_arsize_o     (bus_arsize_o),
    .bus_arvalid_o    (bus_arvalid_o),
    .bus_arready      (bus_arready),
    .bus_rdata        (bus_rdata),
    .bus_rresp        (bus_rresp),
    .bus_rvalid       (bus_rvalid),
    .bus_rready_o     (bus_rready_o),
    .bus_awaddr_o     (bus_awaddr_o),
    .bus_awsize_o     (bus_awsize_o),
    .bus_awvalid_o    (bus_awvalid_o),
    .bus_awready      (bus_awready),
    .bus_wdata_o      (bus_wdata_o),
    .bus_wstrb_o      (bus_wstrb_o),
    .bus_wvalid_o     (bus_wvalid_o),
    .bus_wready       (bus_wready),
    .bus_bresp        (bus_bresp),
    .bus_bvalid       (bus_bvalid),
    .bus_bready_o     (bus_bready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_load;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  op;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          ar_w, r_w, aw_w, w_w, b_w;
    logic [31:0] exp_data;   // load result or store bus data
    logic [3:0]  exp_strb;
    bit          exp_err;
  } vec_t;

  typedef struct {
    int          nr, nw, lat, nar, naw, nwh, unstable;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [2:0]  arsize, awsize;
    logic [3:0]  wstrb;
    logic        err;
  } obs_t;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last_load;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit ld, logic [31:0] a, logic [31:0] wd, logic [2:0] op,
                              logic [31:0] rd, logic [1:0] rs, int arw, int rw, int aww,
                              int ww, int bw, logic [31:0] ed, logic [3:0] es, bit ee);
    vec_t v;
    v.is_load = ld; v.addr = a; v.wdata = wd; v.op = op; v.rdata = rd; v.resp = rs;
    v.ar_w = arw; v.r_w = rw; v.aw_w = aww; v.w_w = ww; v.b_w = bw;
    v.exp_data = ed; v.exp_strb = es; v.exp_err = ee;
    return v;
  endfunction

  // Reference model: byte-lane arithmetic straight from the load/store rules
  function automatic logic [31:0] model_load(logic [31:0] addr, logic [2:0] op,
                                             logic [31:0] raw);
    logic [31:0] s, b, h;
    s = raw >> (8 * (addr % 4));
    b = s & 32'hFF;
    h = s & 32'hFFFF;
    case (op)
      3'd0:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return s;
    endcase
  endfunction

  function automatic logic [3:0] model_strb(logic [31:0] addr, logic [2:0] op);
    int nbytes;
    int m;
    nbytes = 1 << op[1:0];
    m = ((1 << nbytes) - 1) << (addr % 4);
    return 4'(m & 15);
  endfunction

  function automatic logic [31:0] model_wdata(logic [31:0] addr, logic [31:0] wd);
    return wd << (8 * (addr % 4));
  endfunction

  task automatic clear_bus();
    bus_arready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0; bus_rresp = 2'b00;
    bus_awready = 1'b0; bus_wready = 1'b0; bus_bvalid = 1'b0; bus_bresp = 2'b00;
  endtask

  // Drive one request and act as the bus slave with the given wait counts
  task automatic run_txn(input vec_t v, output obs_t o);
    int k, post, arc, rc, awc, wc, bc;
    bit got, ar_pend, aw_pend, w_pend;
    logic [31:0] pa, paw, pw;
    logic [3:0] ps;
    o = '{default: '0};
    k = 0; post = 0; arc = 0; rc = 0; awc = 0; wc = 0; bc = 0;
    got = 0; ar_pend = 0; aw_pend = 0; w_pend = 0;
    pa = '0; paw = '0; pw = '0; ps = '0;
    lsu_avalid = 1'b1; lsu_ren = v.is_load; lsu_wen = !v.is_load;
    lsu_addr = v.addr; lsu_wdata = v.wdata; lsu_op = v.op;
    while (k < 40 && post < 3) begin
      @(negedge clk);
      k++;
      clear_bus();
      if (got) post++;
      if (lsu_exu_rvalid_o) o.nr++;
      if (lsu_exu_wready_o) o.nw++;
      if ((lsu_exu_rvalid_o || lsu_exu_wready_o) && !got) begin
        got = 1; post = 1; o.lat = k; o.err = lsu_err_o; o.rdata = lsu_rdata_o;
        lsu_avalid = 1'b0; lsu_ren = 1'b0; lsu_wen = 1'b0;
      end
      if (bus_arvalid_o) begin
        if (ar_pend && bus_araddr_o !== pa) o.unstable++;
        if (arc >= v.ar_w) begin
          bus_arready = 1'b1; o.nar++; o.araddr = bus_araddr_o; o.arsize = bus_arsize_o;
          ar_pend = 0;
        end else begin
          ar_pend = 1; pa = bus_araddr_o;
        end
        arc++;
      end
      if (bus_rready_o) begin
        if (rc >= v.r_w) begin
          bus_rvalid = 1'b1; bus_rdata = v.rdata; bus_rresp = v.resp;
        end
        rc++;
      end
      if (bus_awvalid_o) begin
        if (aw_pend && bus_awaddr_o !== paw) o.unstable++;
        if (awc >= v.aw_w) begin
          bus_awready = 1'b1; o.naw++; o.awaddr = bus_awaddr_o; o.awsize = bus_awsize_o;
          aw_pend = 0;
        end else begin
          aw_pend = 1; paw = bus_awaddr_o;
        end
        awc++;
      end
      if (bus_wvalid_o) begin
        if (w_pend && (bus_wdata_o !== pw || bus_wstrb_o !== ps)) o.unstable++;
        if (wc >= v.w_w) begin
          bus_wready = 1'b1; o.nwh++; o.wdata = bus_wdata_o; o.wstrb = bus_wstrb_o;
          w_pend = 0;
        end else begin
          w_pend = 1; pw = bus_wdata_o; ps = bus_wstrb_o;
        end
        wc++;
      end
      if (bus_bready_o) begin
        if (bc >= v.b_w) begin
          bus_bvalid = 1'b1; bus_bresp = v.resp;
        end
        bc++;
      end
    end
    lsu_avalid = 1'b0; lsu_ren = 1'b0; lsu_wen = 1'b0;
  endtask

  task automatic apply(input string nm, input vec_t v);
    obs_t o;
    int lat;
    run_txn(v, o);
    if (v.is_load) lat = 3 + v.ar_w + v.r_w;
    else lat = 3 + ((v.aw_w > v.w_w) ? v.aw_w : v.w_w) + v.b_w;
    chk({nm, "_latency"}, 32'(o.lat), 32'(lat));
    chk({nm, "_err"}, 32'(o.err), 32'(v.exp_err));
    chk({nm, "_unstable"}, 32'(o.unstable), 32'd0);
    if (v.is_load) begin
      chk({nm, "_rvalid_pulses"}, 32'(o.nr), 32'd1);
      chk({nm, "_wready_pulses"}, 32'(o.nw), 32'd0);
      chk({nm, "_ar_handshakes"}, 32'(o.nar), 32'd1);
      chk({nm, "_aw_handshakes"}, 32'(o.naw), 32'd0);
      chk({nm, "_araddr"}, o.araddr, v.addr);
      chk({nm, "_arsize"}, 32'(o.arsize), 32'(v.op[1:0]));
      chk({nm, "_rdata"}, o.rdata, v.exp_data);
      last_load = v.exp_data;
    end else begin
      chk({nm, "_wready_pulses"}, 32'(o.nw), 32'd1);
      chk({nm, "_rvalid_pulses"}, 32'(o.nr), 32'd0);
      chk({nm, "_aw_handshakes"}, 32'(o.naw), 32'd1);
      chk({nm, "_w_handshakes"}, 32'(o.nwh), 32'd1);
      chk({nm, "_ar_handshakes"}, 32'(o.nar), 32'd0);
      chk({nm, "_awaddr"}, o.awaddr, v.addr);
      chk({nm, "_awsize"}, 32'(o.awsize), 32'(v.op[1:0]));
      chk({nm, "_wdata"}, o.wdata, v.exp_data);
      chk({nm, "_wstrb"}, 32'(o.wstrb), 32'(v.exp_strb));
      chk({nm, "_rdata_held"}, o.rdata, last_load);
    end
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    logic [2:0] lops [5];
    int off;
    lops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    last_load = 32'h0;

    // Directed vectors:      ld a             wdata          op    rdata          rs    waits           exp            strb   err
    tbl.push_back(mk(1, 32'h8000_0004, 32'h0, 3'd2, 32'hDEAD_BEEF, 2'd0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 4'h0, 0));
    tbl.push_back(mk(1, 32'h8000_0003, 32'h0, 3'd0, 32'h8012_3456, 2'd0, 0, 0, 0, 0, 0, 32'hFFFF_FF80, 4'h0, 0));
    tbl.push_back(mk(1, 32'h8000_0003, 32'h0, 3'd4, 32'h8012_3456, 2'd0, 0, 0, 0, 0, 0, 32'h0000_0080, 4'h0, 0));
    tbl.push_back(mk(0, 32'h8000_0002, 32'h1234_ABCD, 3'd1, 32'h0, 2'd0, 0, 0, 2, 0, 0, 32'hABCD_0000, 4'hC, 0));
    tbl.push_back(mk(1, 32'h8000_0008, 32'h0, 3'd2, 32'h0BAD_F00D, 2'd2, 0, 0, 0, 0, 0, 32'h0BAD_F00D, 4'h0, 1));
    tbl.push_back(mk(0, 32'h8000_000C, 32'hCAFE_BABE, 3'd2, 32'h0, 2'd0, 0, 0, 0, 0, 0, 32'hCAFE_BABE, 4'hF, 0));
    tbl.push_back(mk(1, 32'h8000_0002, 32'h0, 3'd1, 32'h8001_1234, 2'd0, 1, 2, 0, 0, 0, 32'hFFFF_8001, 4'h0, 0));
    tbl.push_back(mk(1, 32'h8000_0002, 32'h0, 3'd5, 32'h8001_1234, 2'd0, 0, 0, 0, 0, 0, 32'h0000_8001, 4'h0, 0));
    tbl.push_back(mk(0, 32'h8000_0001, 32'h0000_00A5, 3'd0, 32'h0, 2'd0, 0, 0, 0, 2, 1, 32'h0000_A500, 4'h2, 0));
    tbl.push_back(mk(1, 32'h8000_0000, 32'h0, 3'd1, 32'h1234_7FFF, 2'd0, 0, 0, 0, 0, 0, 32'h0000_7FFF, 4'h0, 0));
    tbl.push_back(mk(0, 32'h8000_0010, 32'h0102_0304, 3'd2, 32'h0, 2'd3, 0, 0, 0, 1, 0, 32'h0102_0304, 4'hF, 1));
`ifndef YSYX_LSU_MISALIGN_EN
    // Misaligned accesses go out unchanged; lanes past byte 3 are dropped
    tbl.push_back(mk(1, 32'h8000_0001, 32'h0, 3'd2, 32'h1122_3344, 2'd0, 0, 0, 0, 0, 0, 32'h0011_2233, 4'h0, 0));
    tbl.push_back(mk(0, 32'h8000_0003, 32'hAABB_CCDD, 3'd2, 32'h0, 2'd0, 0, 0, 0, 0, 0, 32'hDD00_0000, 4'h8, 0));
`endif

    rst = 1'b1;
    lsu_avalid = 1'b0; lsu_ren = 1'b0; lsu_wen = 1'b0;
    lsu_addr = 32'h0; lsu_wdata = 32'h0; lsu_op = 3'd0;
    clear_bus();
    repeat (3) @(negedge clk);
    chk("reset_arvalid", 32'(bus_arvalid_o), 32'd0);
    chk("reset_rready", 32'(bus_rready_o), 32'd0);
    chk("reset_awvalid", 32'(bus_awvalid_o), 32'd0);
    chk("reset_wvalid", 32'(bus_wvalid_o), 32'd0);
    chk("reset_bready", 32'(bus_bready_o), 32'd0);
    chk("reset_wstrb", 32'(bus_wstrb_o), 32'd0);
    chk("reset_pulses", 32'({lsu_exu_rvalid_o, lsu_exu_wready_o, lsu_err_o}), 32'd0);
    chk("reset_rdata", lsu_rdata_o, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

    // Reset while waiting in RDATA abandons the load with no completion
    lsu_avalid = 1'b1; lsu_ren = 1'b1; lsu_wen = 1'b0;
    lsu_addr = 32'h8000_0020; lsu_op = 3'd2;
    @(negedge clk);
    chk("rstseq_arvalid", 32'(bus_arvalid_o), 32'd1);
    bus_arready = 1'b1;
    @(negedge clk);
    bus_arready = 1'b0;
    chk("rstseq_rready", 32'(bus_rready_o), 32'd1);
    rst = 1'b1; lsu_avalid = 1'b0; lsu_ren = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rstseq_bus_idle", 32'({bus_arvalid_o, bus_rready_o, bus_awvalid_o, bus_wvalid_o,
                                bus_bready_o}), 32'd0);
    chk("rstseq_rdata", lsu_rdata_o, 32'h0);
    last_load = 32'h0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rstseq_no_pulse%0d", i), 32'({lsu_exu_rvalid_o, lsu_exu_wready_o}), 32'd0);
      @(negedge clk);
    end
    apply("after_rst_lw", mk(1, 32'h8000_0024, 32'h0, 3'd2, 32'h5A5A_1234, 2'd0,
                             0, 0, 0, 0, 0, 32'h5A5A_1234, 4'h0, 0));

    // Randomized transactions against the model
    for (int i = 0; i < 40; i++) begin
      v.is_load = bit'($urandom_range(0, 1));
      v.op = v.is_load ? lops[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      off = int'($urandom_range(0, 3));
`ifdef YSYX_LSU_MISALIGN_EN
      if (v.op[1:0] == 2'd1) off = off & 2;
      if (v.op[1:0] == 2'd2) off = 0;
`endif
      v.addr = 32'h8000_0000 | ($urandom & 32'h0000_0FFC) | 32'(off);
      v.wdata = $urandom;
      v.rdata = $urandom;
      v.resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      v.ar_w = int'($urandom_range(0, 2)); v.r_w = int'($urandom_range(0, 2));
      v.aw_w = int'($urandom_range(0, 2)); v.w_w = int'($urandom_range(0, 2));
      v.b_w = int'($urandom_range(0, 2));
      v.exp_err = (v.resp != 2'd0);
      if (v.is_load) begin
        v.exp_data = model_load(v.addr, v.op, v.rdata);
        v.exp_strb = 4'h0;
      end else begin
        v.exp_data = model_wdata(v.addr, v.wdata);
        v.exp_strb = model_strb(v.addr, v.op);
      end
      apply($sformatf("rnd%0d", i), v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
